// File: rtl/spi_slave_burst_if.sv
// rtl/spi_slave_burst_if.sv - user-side tx/rx handshake and frame status bundle for spi_slave_burst
interface spi_slave_burst_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;
  logic [CNTW-1:0]  frame_words;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun, busy, frame_words
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun, busy, frame_words
  );
endinterface

// File: rtl/spi_slave_burst.sv
// rtl/spi_slave_burst.sv - SPI slave, all four modes, any word width, multi-word bursts per SS frame
// Optional: define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_slave_burst #(
  parameter int               WIDTH = 8,
  parameter bit               CPOL  = 1'b0,
  parameter bit               CPHA  = 1'b1,
  parameter logic [WIDTH-1:0] FILL  = '0,
  parameter int               CNTW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_burst_if.slave  bus,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe
);
  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;

  logic [2:0]       sck_sy, ss_sy;
  logic [1:0]       mosi_sy;
  logic [WIDTH-1:0] tx_sr, tx_shifted, rx_next;
  logic [WIDTH-2:0] rx_sr, rx_keep;
  logic [BW-1:0]    bitcount;
  logic [WIDTH-1:0] rx_word;
  logic [CNTW-1:0]  words;
  logic             rx_strobe, tx_bit;
  logic             sck_lead, sck_trail, sample_edge, shift_edge, ss_fall, ss_rise;
  logic             do_load, do_shift, do_sample;

  // [1] is the synchronised level, [2] the previous level for edge detection
  assign sck_lead    = (sck_sy[1] != CPOL) && (sck_sy[2] == CPOL);
  assign sck_trail   = (sck_sy[1] == CPOL) && (sck_sy[2] != CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead : sck_trail;
  assign ss_fall     = !ss_sy[1] && ss_sy[2];
  assign ss_rise     = ss_sy[1] && !ss_sy[2];

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign tx_bit     = tx_sr[0];
  assign tx_shifted = {1'b0, tx_sr[WIDTH-1:1]};
  assign rx_next    = {mosi_sy[1], rx_sr};
  assign rx_keep    = rx_next[WIDTH-1:1];
`else
  assign tx_bit     = tx_sr[WIDTH-1];
  assign tx_shifted = {tx_sr[WIDTH-2:0], 1'b0};
  assign rx_next    = {rx_sr, mosi_sy[1]};
  assign rx_keep    = rx_next[WIDTH-2:0];
`endif

  always_comb begin
    state_nx  = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx = ACTIVE;
          do_load  = !CPHA;
        end
      end
      ACTIVE: begin
        // an SS rise masks any SCK edge detected in the same cycle
        if (ss_rise) begin
          state_nx = IDLE;
        end else begin
          do_sample = sample_edge;
          do_load   = shift_edge && (bitcount == '0);
          do_shift  = shift_edge && (bitcount != '0);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sck_sy    <= {3{CPOL}};
      ss_sy     <= 3'b111;
      mosi_sy   <= 2'b00;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bitcount  <= '0;
      rx_word   <= '0;
      rx_strobe <= 1'b0;
      words     <= '0;
    end else begin
      state     <= state_nx;
      sck_sy    <= {sck_sy[1:0], sck};
      ss_sy     <= {ss_sy[1:0], ss_n};
      mosi_sy   <= {mosi_sy[0], mosi};
      rx_strobe <= 1'b0;

      if (do_load) begin
        tx_sr <= bus.tx_valid ? bus.tx_data : FILL;
      end else if (do_shift) begin
        tx_sr <= tx_shifted;
      end

      if (state == IDLE && ss_fall) begin
        bitcount <= '0;
        words    <= '0;
      end

      // partial word is dropped; words keeps its count until the next frame
      if (state == ACTIVE && ss_rise) begin
        bitcount <= '0;
        rx_sr    <= '0;
        tx_sr    <= '0;
      end

      if (do_sample) begin
        rx_sr <= rx_keep;
        if (bitcount == LAST_BIT) begin
          bitcount  <= '0;
          rx_word   <= rx_next;
          rx_strobe <= 1'b1;
          if (words != '1) begin
            words <= words + 1'b1;
          end
        end else begin
          bitcount <= bitcount + 1'b1;
        end
      end
    end
  end

  assign bus.tx_ready    = do_load && bus.tx_valid;
  assign bus.tx_underrun = do_load && !bus.tx_valid;
  assign bus.rx_data     = rx_word;
  assign bus.rx_valid    = rx_strobe;
  assign bus.frame_words = words;
  assign bus.busy        = (state == ACTIVE);
  assign miso_oe         = (state == ACTIVE);
  assign miso            = (state == ACTIVE) && tx_bit;
endmodule

// File: tb/tb_spi_slave_burst.sv
// tb/tb_spi_slave_burst.sv - scoreboard bench for spi_slave_burst in two configurations
// dut_a: WIDTH 8, CPOL 0, CPHA 1; dut_b: WIDTH 16, CPOL 1, CPHA 0, 2-bit word counter
`timescale 1ns/1ps
module tb_spi_slave_burst;
  localparam int HALF = 6;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_burst_if #(.WIDTH(8),  .CNTW(8)) bus_a ();
  spi_slave_burst_if #(.WIDTH(16), .CNTW(2)) bus_b ();

  logic sck_a, mosi_a, ss_n_a, miso_a, oe_a;
  logic sck_b, mosi_b, ss_n_b, miso_b, oe_b;

  spi_slave_burst #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .FILL(8'h00), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .sck(sck_a), .mosi(mosi_a), .ss_n(ss_n_a), .miso(miso_a), .miso_oe(oe_a)
  );

  spi_slave_burst #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b0), .FILL(16'h0000), .CNTW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .sck(sck_b), .mosi(mosi_b), .ss_n(ss_n_b), .miso(miso_b), .miso_oe(oe_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] txq_a[$], txq_b[$];
  logic [31:0] rxq_a[$], rxq_b[$];
  int rd_a = 0, rd_b = 0, rxrd_a = 0, rxrd_b = 0;
  int rdy_a = 0, unr_a = 0, rxv_a = 0;
  int rdy_b = 0, unr_b = 0, rxv_b = 0;
  logic take_a = 1'b0, take_b = 1'b0;

  // tx_ready is seen mid-cycle; the word it refers to is retired after the capturing edge
  always @(negedge clk) begin
    take_a = bus_a.tx_ready;
    take_b = bus_b.tx_ready;
    if (bus_a.tx_ready)    rdy_a++;
    if (bus_a.tx_underrun) unr_a++;
    if (bus_b.tx_ready)    rdy_b++;
    if (bus_b.tx_underrun) unr_b++;
    if (bus_a.rx_valid) begin
      rxv_a++;
      if (rxrd_a < rxq_a.size()) check("rx_a", 32'(bus_a.rx_data), rxq_a[rxrd_a]);
      else check("rx_a_extra", 32'(rxrd_a), 32'(rxq_a.size()));
      rxrd_a++;
    end
    if (bus_b.rx_valid) begin
      rxv_b++;
      if (rxrd_b < rxq_b.size()) check("rx_b", 32'(bus_b.rx_data), rxq_b[rxrd_b]);
      else check("rx_b_extra", 32'(rxrd_b), 32'(rxq_b.size()));
      rxrd_b++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (take_a) rd_a++;
    if (take_b) rd_b++;
    bus_a.tx_valid = (rd_a < txq_a.size());
    bus_a.tx_data  = bus_a.tx_valid ? txq_a[rd_a][7:0] : 8'h00;
    bus_b.tx_valid = (rd_b < txq_b.size());
    bus_b.tx_data  = bus_b.tx_valid ? txq_b[rd_b][15:0] : 16'h0000;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sck(input int d, input logic v);
    if (d == 0) sck_a = v; else sck_b = v;
  endtask

  task automatic set_mosi(input int d, input logic v);
    if (d == 0) mosi_a = v; else mosi_b = v;
  endtask

  task automatic set_ss(input int d, input logic v);
    if (d == 0) ss_n_a = v; else ss_n_b = v;
  endtask

  function automatic logic get_miso(input int d);
    return (d == 0) ? miso_a : miso_b;
  endfunction

  // master side of one word; nbits < width gives a truncated word
  task automatic spi_word(input int d, input int width, input int nbits, input logic [31:0] dout,
                          output logic [31:0] din, output logic first);
    logic cpol, cpha;
    int idx;
    cpol  = (d == 1);
    cpha  = (d == 0);
    din   = '0;
    first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      idx = LSB_FIRST ? i : width - 1 - i;
      if (cpha) begin
        set_sck(d, ~cpol);
        set_mosi(d, dout[idx]);
        wait_clk(HALF);
        set_sck(d, cpol);
        din[idx] = get_miso(d);
        wait_clk(HALF);
      end else begin
        set_mosi(d, dout[idx]);
        wait_clk(HALF);
        set_sck(d, ~cpol);
        din[idx] = get_miso(d);
        wait_clk(HALF);
        set_sck(d, cpol);
      end
      if (i == 0) first = din[idx];
    end
  endtask

  logic [31:0] mo[8];
  logic [31:0] ex[8];
  logic        fb0;

  task automatic frame(input int d, input int width, input int nwords, input int tail);
    logic [31:0] din;
    logic        fb;
    set_ss(d, 1'b0);
    wait_clk(HALF);
    for (int w = 0; w < nwords; w++) begin
      if (d == 0) rxq_a.push_back(mo[w]); else rxq_b.push_back(mo[w]);
      spi_word(d, width, width, mo[w], din, fb);
      if (w == 0) fb0 = fb;
      check($sformatf("miso_word_d%0d_w%0d", d, w), din, ex[w]);
    end
    if (tail > 0) spi_word(d, width, tail, mo[nwords], din, fb);
    wait_clk(HALF);
    set_ss(d, 1'b1);
    wait_clk(8);
  endtask

  int r0, u0, v0;
  logic [31:0] dummy;
  logic        dfb;

  initial begin
    sck_a = 1'b0; mosi_a = 1'b0; ss_n_a = 1'b1;
    sck_b = 1'b1; mosi_b = 1'b0; ss_n_b = 1'b1;
    rst_n = 1'b0;
    wait_clk(4);
    check("rst_busy_a",  32'(bus_a.busy), 0);
    check("rst_oe_a",    32'(oe_a), 0);
    check("rst_miso_a",  32'(miso_a), 0);
    check("rst_rx_a",    32'(bus_a.rx_data), 0);
    check("rst_fw_a",    32'(bus_a.frame_words), 0);
    check("rst_oe_b",    32'(oe_b), 0);
    check("rst_fw_b",    32'(bus_b.frame_words), 0);
    rst_n = 1'b1;
    wait_clk(4);

    // single word, mode 1
    txq_a.push_back(32'hA5); mo[0] = 32'h3C; ex[0] = 32'hA5;
    r0 = rdy_a; v0 = rxv_a;
    frame(0, 8, 1, 0);
    check("t1_ready_cnt", 32'(rdy_a - r0), 1);
    check("t1_rxv_cnt",   32'(rxv_a - v0), 1);
    check("t1_fw",        32'(bus_a.frame_words), 1);
    check("t1_rx_data",   32'(bus_a.rx_data), 32'h3C);
    check("t1_oe_after",  32'(oe_a), 0);

    // three-word burst, last word underruns
    txq_a.push_back(32'h11); txq_a.push_back(32'h22);
    mo[0] = 32'h81; mo[1] = 32'h42; mo[2] = 32'hE7;
    ex[0] = 32'h11; ex[1] = 32'h22; ex[2] = 32'h00;
    r0 = rdy_a; u0 = unr_a;
    frame(0, 8, 3, 0);
    check("t2_ready_cnt",    32'(rdy_a - r0), 2);
    check("t2_underrun_cnt", 32'(unr_a - u0), 1);
    check("t2_fw",           32'(bus_a.frame_words), 3);

    // mode 2 (CPOL 1, CPHA 0), 16-bit: word loaded at SS fall, reload at final trailing edge
    txq_b.push_back(32'hBEEF); mo[0] = 32'h1234; ex[0] = 32'hBEEF;
    r0 = rdy_b; u0 = unr_b;
    frame(1, 16, 1, 0);
    check("t3_rx_data",      32'(bus_b.rx_data), 32'h1234);
    check("t3_fw",           32'(bus_b.frame_words), 1);
    check("t3_ready_cnt",    32'(rdy_b - r0), 1);
    check("t3_underrun_cnt", 32'(unr_b - u0), 1);

    // four words into a 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      txq_b.push_back(32'h0101 * (i + 1));
      ex[i] = 32'h0101 * (i + 1);
      mo[i] = 32'hF00D ^ (32'h1111 * i);
    end
    frame(1, 16, 4, 0);
    check("t4_fw_sat", 32'(bus_b.frame_words), 3);

    // SS raised after 5 bits of the second word
    txq_a.push_back(32'h96); txq_a.push_back(32'h0F);
    mo[0] = 32'hC3; mo[1] = 32'hFF; ex[0] = 32'h96;
    r0 = rdy_a; v0 = rxv_a;
    frame(0, 8, 1, 5);
    check("t5_rxv_cnt",   32'(rxv_a - v0), 1);
    check("t5_ready_cnt", 32'(rdy_a - r0), 2);
    check("t5_fw_held",   32'(bus_a.frame_words), 1);
    check("t5_oe",        32'(oe_a), 0);
    check("t5_miso",      32'(miso_a), 0);
    check("t5_rx_data",   32'(bus_a.rx_data), 32'hC3);
    txq_a.push_back(32'h5A); mo[0] = 32'h69; ex[0] = 32'h5A;
    frame(0, 8, 1, 0);
    check("t5b_rx_data", 32'(bus_a.rx_data), 32'h69);
    check("t5b_fw",      32'(bus_a.frame_words), 1);

    // reset mid-word
    txq_a.push_back(32'h77);
    set_ss(0, 1'b0);
    wait_clk(HALF);
    spi_word(0, 8, 3, 32'hAA, dummy, dfb);
    rst_n = 1'b0;
    #1;
    check("t6_miso",     32'(miso_a), 0);
    check("t6_oe",       32'(oe_a), 0);
    check("t6_busy",     32'(bus_a.busy), 0);
    check("t6_fw",       32'(bus_a.frame_words), 0);
    check("t6_rx_data",  32'(bus_a.rx_data), 0);
    check("t6_rx_valid", 32'(bus_a.rx_valid), 0);
    check("t6_tx_ready", 32'(bus_a.tx_ready), 0);
    check("t6_oe_b",     32'(oe_b), 0);
    set_ss(0, 1'b1);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    txq_a.push_back(32'h33); mo[0] = 32'h5C; ex[0] = 32'h33;
    frame(0, 8, 1, 0);
    check("t6b_rx_data", 32'(bus_a.rx_data), 32'h5C);
    check("t6b_fw",      32'(bus_a.frame_words), 1);

    // bit-order probe: first miso bit is the LSB only in the LSB-first build
    txq_a.push_back(32'h01); mo[0] = 32'h80; ex[0] = 32'h01;
    frame(0, 8, 1, 0);
    check("t7_first_bit", 32'(fb0), LSB_FIRST ? 32'd1 : 32'd0);
    check("t7_rx_data",   32'(bus_a.rx_data), 32'h80);

    wait_clk(10);
    check("rx_a_pending", 32'(rxrd_a), 32'(rxq_a.size()));
    check("rx_b_pending", 32'(rxrd_b), 32'(rxq_b.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
Parametrised SPI slave for FPGA-side register and peripheral access from the MCU. It supports all four SPI modes, any word width, and multi-word bursts within one SS assertion. It uses a valid/ready transmit handshake with underrun fill and a single-cycle receive strobe. It sits between the MCU SPI pins and user logic, and is the general replacement for fixed 8-bit mode-1 slaves.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
CPOL, 0, SCK idle level
CPHA, 1, 0 = sample on leading edge and shift on trailing; 1 = shift on leading and sample on trailing
FILL, 0, WIDTH-bit word sent when no tx word is available
CNTW, 8, width of the frame word counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_data  in  WIDTH  next word to send (slave to master)
tx_valid  in  1  tx_data is valid
tx_ready  out  1  1-cycle pulse: tx_data captured this cycle
rx_data  out  WIDTH  last complete received word; held until the next word completes
rx_valid  out  1  1-cycle pulse: rx_data updated
tx_underrun  out  1  1-cycle pulse: FILL loaded because tx_valid was 0
busy  out  1  synchronised SS asserted
frame_words  out  CNTW  completed words in current/last frame, saturating
sck, mosi, ss_n  in  1 each  SPI pins from master (asynchronous)
miso  out  1  serial data to master
miso_oe  out  1  tri-state enable for miso, equals busy

Behaviour:
- Synchroniser: sck, mosi and ss_n each pass through 2 flops (reset values CPOL, 0, 1), then a third stage for edge detection. Pin-to-action latency is 3 clk. clk must be at least 8x the SCK frequency.
- Leading edge = synchronised sck leaves CPOL; trailing edge = returns to CPOL.
- States:
  - IDLE: ss_n high.
  - ACTIVE: ss_n low.
  - IDLE to ACTIVE on ss_n falling; ACTIVE to IDLE on ss_n rising, from any bit position.
- Entering ACTIVE:
  - bitcount = 0; frame_words = 0.
  - CPHA=0: a tx word is loaded immediately (same cycle as the ss fall is detected).
- Tx load rule:
  - CPHA=1: load at the leading edge when bitcount == 0.
  - CPHA=0: load at ss entry and at the trailing edge that completes each word.
  - If tx_valid = 1: load tx_data and pulse tx_ready.
  - Else: load FILL and pulse tx_underrun.
  - tx_ready and tx_underrun are never both high.
- Shift out:
  - MSB first; miso = shift register MSB.
  - Shift advances on the non-sampling edge, except the edge that performs a load.
- Sample:
  - On the sampling edge, shift mosi into the rx shift register and increment bitcount.
  - When bitcount reaches WIDTH: rx_data <= assembled word, rx_valid pulses the next cycle, bitcount wraps to 0, frame_words increments (saturates at 2^CNTW-1).
- Burst: the next word follows back-to-back with no dead SCK cycles; the handshake repeats per word.
- SS rise mid-word:
  - Partial word discarded; no rx_valid.
  - bitcount = 0; miso = 0; miso_oe = 0.
  - frame_words holds its value until the next SS fall.
- Simultaneous ss rise and sck edge: ss rise wins and the edge is ignored.
- While IDLE: miso = 0 and tx_data is not consumed.
- Reset (any time, including mid-frame):
  - State IDLE; shift registers 0; rx_data 0; frame_words 0.
  - All pulse outputs, miso and miso_oe = 0.
  - The first frame after reset requires a fresh SS fall.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN:
- Defined: both tx and rx shift LSB first. miso = tx shift register bit 0, shifting right; mosi enters at bit WIDTH-1. rx_data is in natural bit order.
- Undefined: MSB first as above.
- Handshake, timing and counters are identical in both builds.

Test Plan:
- WIDTH=8, CPOL=0, CPHA=1, tx_data=0xA5 held valid, master sends 0x3C in one frame -> miso bits 1,0,1,0,0,1,0,1; one tx_ready; rx_data=0x3C with one rx_valid; frame_words=1.
- Same config, 3-word burst, tx queue 0x11,0x22 then tx_valid=0 -> words 0x11,0x22,0x00 returned; tx_underrun pulses once on word 3; frame_words=3.
- CPOL=1, CPHA=0, WIDTH=16, tx 0xBEEF loaded at SS fall, master sends 0x1234 -> first miso bit valid before the first SCK edge; master reads 0xBEEF; rx_data=0x1234.
- SS raised after 5 of 8 bits -> no rx_valid; miso_oe=0; next frame exchanges a full correct word starting at bit 7.
- rst_n pulsed low mid-word -> all outputs 0 immediately; a new SS frame after release works normally.
- With SPI_SLAVE_LSB_FIRST_EN, tx 0x01, master sends 0x80 LSB-first -> first miso bit 1; rx_data=0x80.
